// File: rtl/servo_slew_pwm_if.sv
// Servo output stage bus: target handshake, enable request and pulse/status outputs.
interface servo_slew_pwm_if #(
  parameter int unsigned PW_W = 8
) ();
  logic            enable;
  logic            tgt_valid;
  logic            tgt_ready;
  logic [PW_W-1:0] tgt_pw;
  logic            servout;
  logic [PW_W-1:0] cur_pw;
  logic            at_target;
  logic            frame_start;

  modport master (
    output enable, tgt_valid, tgt_pw,
    input  tgt_ready, servout, cur_pw, at_target, frame_start
  );

  modport slave (
    input  enable, tgt_valid, tgt_pw,
    output tgt_ready, servout, cur_pw, at_target, frame_start
  );
endinterface

// File: rtl/servo_slew_pwm.sv
// Servo output stage: one-deep clamped target slot, per-frame slew of the active
// width and whole 50 Hz pulses. Optional macro SERVO_SLEW_EN enables STEP slew limiting.
module servo_slew_pwm #(
  parameter int unsigned FRAME_TICKS = 1000,
  parameter int unsigned PW_W        = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned MIN_PW      = 25,
  parameter int unsigned MAX_PW      = 60,
  parameter int unsigned PARK_PW     = 27
) (
  input  logic            clkin,
  input  logic            rst,
  servo_slew_pwm_if.slave bus
);

  localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned CMP_W = (CNT_W > PW_W) ? CNT_W : PW_W;
  localparam int unsigned SUM_W = PW_W + 1;
  localparam int unsigned FULL_RANGE = 32'd1 << PW_W;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  // Without slew limiting the step covers the whole width range, so every
  // change of target lands at a single wrap.
  localparam int unsigned STEP_EFF = (SLEW_ON && (STEP < FULL_RANGE)) ? STEP : FULL_RANGE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [PW_W-1:0]  MIN_V    = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0]  MAX_V    = PW_W'(MAX_PW);
  localparam logic [PW_W-1:0]  PARK_V   = PW_W'(PARK_PW);
  localparam logic [SUM_W-1:0] STEP_V   = SUM_W'(STEP_EFF);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW_W-1:0]  pend_pw_q,   pend_pw_d;
  logic             pend_full_q, pend_full_d;
  logic [PW_W-1:0]  act_tgt_q,   act_tgt_d;
  logic [PW_W-1:0]  cur_pw_q,    cur_pw_d;
  logic             en_frame_q,  en_frame_d;
  logic             servout_q,   servout_d;
  logic             tgt_ready_q, tgt_ready_d;
  logic             at_target_q, at_target_d;
  logic             frame_start_q, frame_start_d;
  logic             wrap_c;
  logic             xfer_c;

  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v);
    if (v < MIN_V) begin
      clamp_pw = MIN_V;
    end else if (v > MAX_V) begin
      clamp_pw = MAX_V;
    end else begin
      clamp_pw = v;
    end
  endfunction

  // One bounded move of cur toward tgt; the extra bit keeps cur+STEP from wrapping.
  function automatic logic [PW_W-1:0] slew_pw(input logic [PW_W-1:0] cur,
                                              input logic [PW_W-1:0] tgt);
    logic [SUM_W-1:0] c;
    logic [SUM_W-1:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) begin
      slew_pw = ((t - c) <= STEP_V) ? tgt : PW_W'(c + STEP_V);
    end else begin
      slew_pw = ((c - t) <= STEP_V) ? tgt : PW_W'(c - STEP_V);
    end
  endfunction

  // Next-state: handshake into the slot, frame wrap loads/slews, pulse compare.
  always_comb begin
    frame_cnt_d   = frame_cnt_q + CNT_W'(1);
    pend_pw_d     = pend_pw_q;
    pend_full_d   = pend_full_q;
    act_tgt_d     = act_tgt_q;
    cur_pw_d      = cur_pw_q;
    en_frame_d    = en_frame_q;
    wrap_c        = (frame_cnt_q == CNT_LAST);
    xfer_c        = bus.tgt_valid && tgt_ready_q;

    if (xfer_c) begin
      pend_pw_d   = clamp_pw(bus.tgt_pw);
      pend_full_d = 1'b1;
    end

    if (wrap_c) begin
      frame_cnt_d = '0;
      en_frame_d  = bus.enable;
      if (pend_full_q) begin
        act_tgt_d   = pend_pw_q;
        pend_full_d = 1'b0;
      end
      cur_pw_d = slew_pw(cur_pw_q, act_tgt_d);
    end

    servout_d     = en_frame_q && (CMP_W'(frame_cnt_q) < CMP_W'(cur_pw_q));
    tgt_ready_d   = !pend_full_d;
    at_target_d   = (cur_pw_d == act_tgt_d) && !pend_full_d;
    frame_start_d = (frame_cnt_d == '0);
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      pend_pw_q     <= '0;
      pend_full_q   <= 1'b0;
      act_tgt_q     <= PARK_V;
      cur_pw_q      <= PARK_V;
      en_frame_q    <= 1'b0;
      servout_q     <= 1'b0;
      tgt_ready_q   <= 1'b1;
      at_target_q   <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      pend_pw_q     <= pend_pw_d;
      pend_full_q   <= pend_full_d;
      act_tgt_q     <= act_tgt_d;
      cur_pw_q      <= cur_pw_d;
      en_frame_q    <= en_frame_d;
      servout_q     <= servout_d;
      tgt_ready_q   <= tgt_ready_d;
      at_target_q   <= at_target_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.servout     = servout_q;
  assign bus.cur_pw      = cur_pw_q;
  assign bus.tgt_ready   = tgt_ready_q;
  assign bus.at_target   = at_target_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_slew_pwm.sv
// Self-checking bench for servo_slew_pwm against a frame-level behavioural model.
module tb_servo_slew_pwm;

  localparam int FRAME   = 1000;
  localparam int MIN_PW  = 25;
  localparam int MAX_PW  = 60;
  localparam int PARK_PW = 27;
`ifdef SERVO_SLEW_EN
  localparam int STEP_EFF = 1;
`else
  localparam int STEP_EFF = 256;
`endif

  logic clkin = 1'b0;
  logic rst   = 1'b1;

  servo_slew_pwm_if #(.PW_W(8)) bus ();

  servo_slew_pwm #(
    .FRAME_TICKS(FRAME), .PW_W(8), .STEP(1),
    .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .PARK_PW(PARK_PW)
  ) dut (
    .clkin(clkin),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset, frame-level width/target/enable, pending slot.
  int n;
  int m_cur, m_act;
  bit m_en;
  int m_pend[$];
  bit e_servout, e_fstart, e_ready, e_at;

  function automatic int clamp_pw(input int v);
    return (v < MIN_PW) ? MIN_PW : ((v > MAX_PW) ? MAX_PW : v);
  endfunction

  function automatic int move_toward(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > STEP_EFF)  d = STEP_EFF;
    if (d < -STEP_EFF) d = -STEP_EFF;
    return cur + d;
  endfunction

  task automatic model_reset();
    n = 0; m_cur = PARK_PW; m_act = PARK_PW; m_en = 1'b0; m_pend.delete();
    e_servout = 1'b0; e_fstart = 1'b0; e_ready = 1'b1; e_at = 1'b1;
  endtask

  task automatic do_reset();
    bus.tgt_valid = 1'b0;
    rst = 1'b1;
    @(posedge clkin); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: dacc reports the DUT-side handshake; the model advances in parallel.
  task automatic step(output bit dacc);
    bit macc, en_p, en_in;
    int fc, cur_p, pw_in;
    dacc  = bus.tgt_valid && bus.tgt_ready;
    macc  = bus.tgt_valid && (m_pend.size() == 0);
    fc    = n % FRAME;
    en_p  = m_en;
    cur_p = m_cur;
    pw_in = int'(bus.tgt_pw);
    en_in = bus.enable;
    @(posedge clkin); #1;
    n++;
    if (n % FRAME == 0) begin
      m_en = en_in;
      if (m_pend.size() != 0) m_act = m_pend.pop_front();
      m_cur = move_toward(m_cur, m_act);
    end
    if (macc) m_pend.push_back(clamp_pw(pw_in));
    e_servout = en_p && (fc < cur_p);
    e_fstart  = (n % FRAME == 0);
    e_ready   = (m_pend.size() == 0);
    e_at      = (m_cur == m_act) && (m_pend.size() == 0);
  endtask

  task automatic advance_to(input int fc);
    bit d;
    while (n % FRAME != fc) step(d);
  endtask

  // Runs to the next frame start, collecting pulse width and model disagreements.
  task automatic run_to_wrap(input int en_at, input bit en_val,
                             output int width, output int bad, output int first_hi);
    bit d;
    width = 0; bad = 0; first_hi = -1;
    do begin
      if (n % FRAME == en_at) bus.enable = en_val;
      step(d);
      if (bus.servout === 1'b1) begin
        width++;
        if (first_hi < 0) first_hi = n;
      end
      if (bus.servout !== e_servout) bad++;
    end while (n % FRAME != 0);
  endtask

  task automatic send(input int v, output bit ok);
    bus.tgt_valid = 1'b1;
    bus.tgt_pw    = 8'(v);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) step(ok);
    bus.tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    int w, bad, fh;
    bus.enable = 1'b1;
    do_reset();
    checks++; if (bus.servout !== 1'b0) begin errors++; $display("FAIL reset_servout got %b exp 0", bus.servout); end
    checks++; if (int'(bus.cur_pw) != PARK_PW) begin errors++; $display("FAIL reset_cur_pw got %0d exp %0d", bus.cur_pw, PARK_PW); end
    checks++; if (bus.tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_tgt_ready got %b exp 1", bus.tgt_ready); end
    checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target got %b exp 1", bus.at_target); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", bus.frame_start); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (w != 0 || bad != 0) begin errors++; $display("FAIL reset_frame0 width %0d bad %0d exp 0 0", w, bad); end
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL reset_fstart_wrap got %b exp 1", bus.frame_start); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (fh != 1001) begin errors++; $display("FAIL reset_first_rise got %0d exp 1001", fh); end
    checks++; if (w != PARK_PW || bad != 0) begin errors++; $display("FAIL reset_first_width got %0d bad %0d exp %0d 0", w, bad, PARK_PW); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (fh != 2001 || w != PARK_PW) begin errors++; $display("FAIL reset_repeat rise %0d width %0d exp 2001 %0d", fh, w, PARK_PW); end
  endtask

  task automatic test_ramp();
    int w, bad, fh, expv, reached;
    bit ok;
    advance_to(500);
    send(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ramp_accept got 0 exp 1"); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (bad != 0) begin errors++; $display("FAIL ramp_send_frame bad %0d exp 0", bad); end
    reached = 0;
    for (int f = 1; f <= 20; f++) begin
      expv = 27 + f * STEP_EFF;
      if (expv > 40) expv = 40;
      checks++; if (int'(bus.cur_pw) != expv) begin errors++; $display("FAIL ramp_cur_pw f%0d got %0d exp %0d", f, bus.cur_pw, expv); end
      checks++; if (bus.at_target !== (expv == 40)) begin errors++; $display("FAIL ramp_at_target f%0d got %b exp %b", f, bus.at_target, expv == 40); end
      if (expv == 40) begin
        reached = f;
        break;
      end
      run_to_wrap(-1, 1'b0, w, bad, fh);
      checks++; if (w != expv || bad != 0) begin errors++; $display("FAIL ramp_width f%0d got %0d bad %0d exp %0d", f, w, bad, expv); end
    end
    checks++; if (reached != (13 + STEP_EFF - 1) / STEP_EFF) begin errors++; $display("FAIL ramp_wraps got %0d exp %0d", reached, (13 + STEP_EFF - 1) / STEP_EFF); end
  endtask

  task automatic test_enable();
    int w, bad, fh;
    checks++; if (int'(bus.cur_pw) != 40) begin errors++; $display("FAIL enable_start_cur got %0d exp 40", bus.cur_pw); end
    run_to_wrap(10, 1'b0, w, bad, fh);
    checks++; if (w != 40 || bad != 0) begin errors++; $display("FAIL enable_drop_width got %0d bad %0d exp 40 0", w, bad); end
    run_to_wrap(500, 1'b1, w, bad, fh);
    checks++; if (w != 0 || bad != 0) begin errors++; $display("FAIL enable_off_frame got %0d bad %0d exp 0 0", w, bad); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (w != 40 || fh % FRAME != 1) begin errors++; $display("FAIL enable_restart width %0d rise_fc %0d exp 40 1", w, fh % FRAME); end
  endtask

  task automatic test_back_to_back();
    int a, b, f0, w, bad, fh;
    bit d;
    a = 38 + $urandom_range(0, 4);
    b = 38 + $urandom_range(0, 4);
    advance_to(300);
    f0 = n / FRAME;
    bus.tgt_valid = 1'b1;
    bus.tgt_pw    = 8'(a);
    step(d);
    checks++; if (!d) begin errors++; $display("FAIL b2b_first_accept got 0 exp 1"); end
    checks++; if (bus.tgt_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %b exp 0", bus.tgt_ready); end
    bus.tgt_pw = 8'(b);
    d = 1'b0;
    for (int i = 0; i < 2 * FRAME && !d; i++) step(d);
    checks++; if (!d || (n - 1) % FRAME != 0 || (n - 1) / FRAME != f0 + 1) begin errors++; $display("FAIL b2b_second acc %b fc %0d frame %0d exp 1 0 %0d", d, (n - 1) % FRAME, (n - 1) / FRAME, f0 + 1); end
    bus.tgt_pw = 8'(40);
    d = 1'b0;
    for (int i = 0; i < 2 * FRAME && !d; i++) step(d);
    checks++; if (!d || (n - 1) % FRAME != 0 || (n - 1) / FRAME != f0 + 2) begin errors++; $display("FAIL b2b_third acc %b fc %0d frame %0d exp 1 0 %0d", d, (n - 1) % FRAME, (n - 1) / FRAME, f0 + 2); end
    bus.tgt_valid = 1'b0;
    for (int f = 0; f < 12 && (bus.at_target !== 1'b1 || n % FRAME != 0); f++) run_to_wrap(-1, 1'b0, w, bad, fh);
    checks++; if (int'(bus.cur_pw) != 40 || bus.at_target !== 1'b1) begin errors++; $display("FAIL b2b_settle cur %0d at %b exp 40 1", bus.cur_pw, bus.at_target); end
  endtask

  task automatic test_rst_midramp();
    int w, bad, fh, expv;
    bit ok;
    bus.enable = 1'b1;
    do_reset();
    advance_to(500);
    send(50, ok);
    run_to_wrap(-1, 1'b0, w, bad, fh);
    expv = (27 + STEP_EFF > 50) ? 50 : 27 + STEP_EFF;
    checks++; if (!ok || int'(bus.cur_pw) != expv) begin errors++; $display("FAIL rst_first_wrap cur %0d acc %b exp %0d 1", bus.cur_pw, ok, expv); end
    run_to_wrap(-1, 1'b0, w, bad, fh);
    advance_to(20);
    checks++; if (bus.servout !== 1'b1) begin errors++; $display("FAIL rst_mid_pulse got %b exp 1", bus.servout); end
    do_reset();
    checks++; if (bus.servout !== 1'b0) begin errors++; $display("FAIL rst_servout got %b exp 0", bus.servout); end
    checks++; if (int'(bus.cur_pw) != PARK_PW) begin errors++; $display("FAIL rst_cur_pw got %0d exp %0d", bus.cur_pw, PARK_PW); end
    checks++; if (bus.tgt_ready !== 1'b1 || bus.at_target !== 1'b1) begin errors++; $display("FAIL rst_status ready %b at %b exp 1 1", bus.tgt_ready, bus.at_target); end
  endtask

  task automatic test_clamp();
    int w, bad, fh, frames;
    bit ok;
    advance_to(500);
    send(10, ok);
    frames = 0;
    for (int f = 1; f <= 6; f++) begin
      run_to_wrap(-1, 1'b0, w, bad, fh);
      checks++; if (int'(bus.cur_pw) < MIN_PW || int'(bus.cur_pw) > MAX_PW) begin errors++; $display("FAIL clamp_lo_range got %0d exp 25..60", bus.cur_pw); end
      if (bus.at_target === 1'b1) begin frames = f; break; end
    end
    checks++; if (int'(bus.cur_pw) != MIN_PW || frames != (2 + STEP_EFF - 1) / STEP_EFF) begin errors++; $display("FAIL clamp_lo got %0d in %0d frames exp %0d in %0d", bus.cur_pw, frames, MIN_PW, (2 + STEP_EFF - 1) / STEP_EFF); end
    send(200, ok);
    frames = 0;
    for (int f = 1; f <= 40; f++) begin
      run_to_wrap(-1, 1'b0, w, bad, fh);
      checks++; if (int'(bus.cur_pw) < MIN_PW || int'(bus.cur_pw) > MAX_PW || bad != 0) begin errors++; $display("FAIL clamp_hi_range got %0d bad %0d exp 25..60 0", bus.cur_pw, bad); end
      if (bus.at_target === 1'b1) begin frames = f; break; end
    end
    checks++; if (int'(bus.cur_pw) != MAX_PW || frames != (35 + STEP_EFF - 1) / STEP_EFF) begin errors++; $display("FAIL clamp_hi got %0d in %0d frames exp %0d in %0d", bus.cur_pw, frames, MAX_PW, (35 + STEP_EFF - 1) / STEP_EFF); end
  endtask

  task automatic test_random();
    bit d;
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000 + int'($urandom_range(0, 400))) do_reset();
      if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
      if (bus.tgt_valid === 1'b0 && $urandom_range(0, 39) == 0) begin
        bus.tgt_valid = 1'b1;
        bus.tgt_pw    = 8'($urandom_range(0, 255));
      end else if (bus.tgt_valid === 1'b1 && $urandom_range(0, 99) == 0) begin
        bus.tgt_valid = 1'b0;
      end
      step(d);
      if (d) bus.tgt_valid = 1'b0;
      checks++; if (bus.servout !== e_servout) begin errors++; $display("FAIL rand_servout n%0d got %b exp %b", n, bus.servout, e_servout); end
      checks++; if (int'(bus.cur_pw) != m_cur) begin errors++; $display("FAIL rand_cur_pw n%0d got %0d exp %0d", n, bus.cur_pw, m_cur); end
      checks++; if (bus.tgt_ready !== e_ready) begin errors++; $display("FAIL rand_tgt_ready n%0d got %b exp %b", n, bus.tgt_ready, e_ready); end
      checks++; if (bus.at_target !== e_at) begin errors++; $display("FAIL rand_at_target n%0d got %b exp %b", n, bus.at_target, e_at); end
      checks++; if (bus.frame_start !== e_fstart) begin errors++; $display("FAIL rand_frame_start n%0d got %b exp %b", n, bus.frame_start, e_fstart); end
    end
    bus.tgt_valid = 1'b0;
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_pw    = '0;
    model_reset();
    test_reset();
    test_ramp();
    test_enable();
    test_back_to_back();
    test_rst_midramp();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_slew_pwm.md
# servo_slew_pwm

Servo output stage downstream of the movement sequencers. It accepts target pulse widths over a valid/ready handshake and slews the active width toward the target by a bounded step once per servo frame. It generates the 50 Hz servo pulse with no truncated or partial pulses. It replaces raw per-sequence pulse generation so that arm movements ramp smoothly instead of snapping.

## Interface
- FRAME_TICKS, 1000: clkin cycles per servo frame (20 ms at the 50 kHz tick).
- PW_W, 8: pulse-width field width.
- STEP, 1: maximum change of the active width per frame.
- MIN_PW, 25: lowest legal width, in ticks.
- MAX_PW, 60: highest legal width, in ticks. Requires MIN_PW ≤ PARK_PW ≤ MAX_PW < FRAME_TICKS.
- PARK_PW, 27: width after reset.
- clkin  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request pulse output; sampled only at frame wrap.
- tgt_valid  in  1  tgt_pw valid.
- tgt_ready  out  1  holding slot free; reset 1.
- tgt_pw  in  PW_W  requested width in ticks.
- servout  out  1  registered servo pulse; reset 0.
- cur_pw  out  PW_W  active width for the current frame; reset PARK_PW.
- at_target  out  1  cur_pw equals the active target and no target is pending; reset 1.
- frame_start  out  1  one-cycle strobe while frame_cnt == 0; reset 0.

## Operation
- Registers:
  - frame_cnt, counts 0..FRAME_TICKS-1 and wraps.
  - pend_pw and pend_full, forming a one-deep holding slot.
  - act_tgt, reset PARK_PW.
  - cur_pw.
  - en_frame, reset 0.
- Handshake:
  - tgt_ready = !pend_full.
  - A transfer occurs when tgt_valid && tgt_ready.
  - The accepted value is clamped on entry to [MIN_PW, MAX_PW] and stored in pend_pw; pend_full is set.
- Wrap cycle (frame_cnt == FRAME_TICKS-1), all updates take effect together:
  - frame_cnt ← 0.
  - en_frame ← enable.
  - If pend_full: act_tgt ← pend_pw and pend_full ← 0. cur_pw steps toward this newly loaded target in the same cycle.
  - If |act_tgt − cur_pw| ≤ STEP, then cur_pw ← act_tgt. Otherwise cur_pw moves by STEP toward act_tgt.
- No transfer happens on a wrap cycle while pend_full is set (tgt_ready is low). A new value can be accepted from the following cycle.
- servout ← en_frame && (frame_cnt < cur_pw), registered every cycle.
- Pulse length and alignment:
  - The high pulse is exactly cur_pw cycles long.
  - It starts the cycle after frame_start.
  - cur_pw and en_frame change only at the wrap, so every pulse is whole.
- States, derived:
  - OFF: en_frame = 0. Targets are still accepted and cur_pw still slews.
  - RAMP: cur_pw ≠ act_tgt.
  - HOLD: cur_pw == act_tgt.
- Clamp arithmetic uses unsigned PW_W-bit compares. Step arithmetic uses PW_W+1 bits internally, so no wrap-around can occur.

## Timing
- Handshake acceptance to act_tgt: at the next wrap, 1 to FRAME_TICKS cycles later.
- act_tgt to cur_pw convergence: ceil(|Δ|/STEP) frames.
- Enable rise mid-frame: pulses start in the frame after the next wrap.
- Enable fall mid-frame: the current pulse completes. Output is 0 from the next frame.
- rst in any cycle, including mid-pulse or mid-ramp: next cycle servout = 0, frame_cnt = 0, pending target dropped, cur_pw = act_tgt = PARK_PW.

## Configuration
- SERVO_SLEW_EN defined: slew limiting by STEP as described above.
- SERVO_SLEW_EN undefined:
  - At each wrap, cur_pw ← act_tgt directly, so any change completes in one frame.
  - The STEP parameter is ignored.
  - at_target is low only while a target is pending or still being loaded.

## Test plan
- Reset with enable = 1 held: servout = 0 and cur_pw = 27 immediately after reset. The first pulse begins 1001 cycles after reset and is 27 cycles wide. The same pulse repeats every 1000 cycles.
- Send tgt_pw = 40 with STEP = 1: cur_pw reads 28, 29, … on successive frames and reaches 40 after 13 wraps. Each pulse width equals that frame's cur_pw. at_target rises at the wrap that sets cur_pw = 40.
- Send tgt_pw = 10, then 200: values are clamped to 25 and 60. cur_pw never leaves [25, 60].
- Send 3 targets back-to-back mid-frame: the first is accepted, then tgt_ready is low until the wrap. The second is accepted the cycle after the wrap. The third waits for the following wrap.
- Drop enable at frame_cnt = 10 while cur_pw = 40: that frame's pulse is the full 40 cycles. servout stays 0 from the next frame. Raising enable again mid-frame restarts pulses only after the next wrap.
- Assert rst at frame_cnt = 20 during a ramp to 50: servout = 0 next cycle. cur_pw = 27, tgt_ready = 1, at_target = 1. A build without SERVO_SLEW_EN sent 50 gives cur_pw = 50 after one wrap.
